// File: rtl/fill_mem_responder.sv
// Memory-side responder for the I/D cache fill protocol: fixed-priority arbiter,
// word array and a fixed-latency read-return pipeline with per-requester strobes.
module fill_mem_responder #(
    parameter int LATENCY   = 4,
    parameter int WORD_BITS = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        wait_for_icache,
    output logic [15:0] mem_data,
    output logic        i_data_valid,
    output logic        d_data_valid
);

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;
    localparam int   DEPTH   = 1 << WORD_BITS;

    logic [15:0]          mem [DEPTH];
    logic [LATENCY-1:0]   pipe_valid;
    logic [LATENCY-1:0]   pipe_owner;
    logic [15:0]          pipe_data [LATENCY];

    logic                 i_grant;
    logic                 d_grant;
    logic                 rd_grant;
    logic                 wr_grant;
    logic [WORD_BITS-1:0] rd_index;
    logic [WORD_BITS-1:0] wr_index;
    logic                 last_valid;
    logic                 unused_addr_bits;

    // I-cache always wins so a fill burst is never broken by D-side traffic.
    assign i_grant         = i_req;
    assign d_grant         = d_req & ~i_req;
    assign rd_grant        = i_grant | (d_grant & ~d_wr);
    assign wr_grant        = d_grant & d_wr;
    assign wait_for_icache = d_req & i_req;

    assign rd_index = i_grant ? i_addr[WORD_BITS:1] : d_addr[WORD_BITS:1];
    assign wr_index = d_addr[WORD_BITS:1];

    assign unused_addr_bits = ^{i_addr[0], d_addr[0]};

    // Only the valid bits are reset: that alone guarantees no stale beat is delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage read its neighbour's
            // pre-edge value, so the loop order does not matter.
            pipe_valid[0] <= rd_grant;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // NOTE: the array and the data/owner payload have no reset; a reset branch on a
    // memory would prevent RAM inference and the payload is qualified by pipe_valid.
    always_ff @(posedge clk) begin
        if (wr_grant) begin
            mem[wr_index] <= d_wdata;
        end
        pipe_data[0]  <= mem[rd_index];
        pipe_owner[0] <= i_grant ? OWNER_I : OWNER_D;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data[i]  <= pipe_data[i-1];
            pipe_owner[i] <= pipe_owner[i-1];
        end
    end

    assign last_valid   = pipe_valid[LATENCY-1];
    assign i_data_valid = last_valid & (pipe_owner[LATENCY-1] == OWNER_I);
    assign d_data_valid = last_valid & (pipe_owner[LATENCY-1] == OWNER_D);
    assign mem_data     = last_valid ? pipe_data[LATENCY-1] : 16'h0000;

endmodule

// File: tb/tb_fill_mem_responder.sv
// Scoreboard bench for fill_mem_responder: a LATENCY=4 and a LATENCY=1 instance
// share the request inputs; expected beats are queued at grant and popped when due.
module tb_fill_mem_responder;

    localparam int L4 = 4;
    localparam int L1 = 1;

    typedef struct {
        int          due;
        logic        owner;
        logic [15:0] data;
    } beat_t;

    logic        clk;
    logic        rst_n;
    logic        i_req;
    logic [15:0] i_addr;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;

    logic        wait4, wait1;
    logic [15:0] data4, data1;
    logic        iv4, iv1, dv4, dv1;

    int          cyc;
    int          total;
    int          bad;
    beat_t       q4[$];
    beat_t       q1[$];
    logic [15:0] model_mem [int];

    fill_mem_responder #(.LATENCY(L4), .WORD_BITS(15)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .wait_for_icache(wait4), .mem_data(data4),
        .i_data_valid(iv4), .d_data_valid(dv4)
    );

    fill_mem_responder #(.LATENCY(L1), .WORD_BITS(15)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .wait_for_icache(wait1), .mem_data(data1),
        .i_data_valid(iv1), .d_data_valid(dv1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_dut(input string name, inout beat_t q[$],
                             input logic iv, input logic dv, input logic [15:0] d);
        logic        exp_iv;
        logic        exp_dv;
        logic [15:0] exp_d;
        beat_t       b;
        exp_iv = 1'b0;
        exp_dv = 1'b0;
        exp_d  = 16'h0000;
        if (q.size() > 0 && q[0].due == cyc) begin
            b      = q.pop_front();
            exp_iv = (b.owner == 1'b0);
            exp_dv = (b.owner == 1'b1);
            exp_d  = b.data;
        end
        check({name, ".i_data_valid"}, {15'd0, iv}, {15'd0, exp_iv});
        check({name, ".d_data_valid"}, {15'd0, dv}, {15'd0, exp_dv});
        check({name, ".mem_data"}, d, exp_d);
    endtask

    task automatic push_read(input logic owner, input logic [15:0] addr);
        beat_t b;
        b.owner = owner;
        b.data  = model_mem[int'(addr[15:1])];
        b.due   = cyc + L4;
        q4.push_back(b);
        b.due   = cyc + L1;
        q1.push_back(b);
    endtask

    // One clock cycle: check what the DUTs present now, then drive this cycle's requests.
    task automatic tick(input logic ir, input logic [15:0] ia, input logic dr,
                        input logic dw, input logic [15:0] da, input logic [15:0] dd);
        @(negedge clk);
        check_dut("L4", q4, iv4, dv4, data4);
        check_dut("L1", q1, iv1, dv1, data1);
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_wr    = dw;
        d_addr  = da;
        d_wdata = dd;
        if (rst_n) begin
            if (ir) push_read(1'b0, ia);
            else if (dr && dw) model_mem[int'(da[15:1])] = dd;
            else if (dr) push_read(1'b1, da);
        end
        #1;
        check("L4.wait_for_icache", {15'd0, wait4}, {15'd0, dr & ir});
        check("L1.wait_for_icache", {15'd0, wait1}, {15'd0, dr & ir});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic dwrite(input logic [15:0] a, input logic [15:0] v);
        tick(1'b0, 16'h0, 1'b1, 1'b1, a, v);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = 16'h0;
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_addr  = 16'h0;
        d_wdata = 16'h0;

        // Reset state; wait_for_icache is combinational even in reset.
        idle(2);
        tick(1'b1, 16'h0040, 1'b1, 1'b0, 16'h0040, 16'h0);
        idle(1);
        #2 rst_n = 1'b1;

        // Preload through the D write port.
        dwrite(16'h0040, 16'hBEEF);
        for (int k = 0; k < 8; k++) dwrite(16'h0100 + 16'(2 * k), 16'hA000 + 16'(k));
        for (int k = 0; k < 3; k++) dwrite(16'h0300 + 16'(2 * k), 16'h1110 + 16'(k));
        dwrite(16'h0400, 16'h5A5A);
        idle(2);

        // Single I read.
        tick(1'b1, 16'h0040, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(6);

        // Fill burst of 8 back-to-back I reads.
        for (int k = 0; k < 8; k++) tick(1'b1, 16'h0100 + 16'(2 * k), 1'b0, 1'b0, 16'h0, 16'h0);
        idle(6);

        // Collision: D read held for 3 cycles behind I reads, granted on the 4th.
        for (int k = 0; k < 3; k++) tick(1'b1, 16'h0300 + 16'(2 * k), 1'b1, 1'b0, 16'h0400, 16'h0);
        tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h0400, 16'h0);
        idle(6);

        // Address bit 0 ignored on both sides.
        tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h0041, 16'h0);
        tick(1'b1, 16'h0103, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(6);

        // Write then read on the next cycle; the write itself yields no beat.
        dwrite(16'h2000, 16'h1234);
        tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h2001, 16'h0);
        idle(6);

        // Ungranted writes (d_req low, or blocked by i_req) must not touch the array.
        tick(1'b0, 16'h0, 1'b0, 1'b1, 16'h0040, 16'hDEAD);
        tick(1'b1, 16'h0102, 1'b1, 1'b1, 16'h0040, 16'h7777);
        tick(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
        idle(6);

        // Reset mid-pipeline: in-flight beats are discarded.
        for (int k = 0; k < 3; k++) tick(1'b1, 16'h0100 + 16'(2 * k), 1'b0, 1'b0, 16'h0, 16'h0);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        check("async L1.i_data_valid", {15'd0, iv1}, 16'h0);
        check("async L1.mem_data", data1, 16'h0);
        check("async L4.i_data_valid", {15'd0, iv4}, 16'h0);
        check("async L4.mem_data", data4, 16'h0);
        q4.delete();
        q1.delete();
        idle(2);
        #2 rst_n = 1'b1;
        tick(1'b1, 16'h0106, 1'b0, 1'b0, 16'h0, 16'h0);
        idle(8);

        // Every queued beat must have been delivered.
        check("q4 drained", 16'(q4.size()), 16'h0);
        check("q1 drained", 16'(q1.size()), 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fill_mem_responder.md
Name: fill_mem_responder

Overview:
- Memory-side responder for the cache fill protocol: the other end of the I-cache and D-cache fill FSMs.
- Accepts one word request per cycle from two requesters: I-cache (read only) and D-cache (read or write).
- Arbitrates between them with fixed I-cache priority and drives the D-side wait signal (`wait_for_icache`).
- Returns read data through a fixed-latency pipeline with per-requester valid strobes, emulating the multi-cycle main memory that the fill FSMs count beats against.

Parameters:
- LATENCY, 4, cycles from accepted read request to its data beat; legal range 1..8.
- WORD_BITS, 15, word-index width; array depth is 2^WORD_BITS 16-bit words, indexed by addr[WORD_BITS:1].

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- i_req  input  1  I-cache read request this cycle
- i_addr  input  16  I-cache byte address; bit 0 ignored
- d_req  input  1  D-cache request this cycle
- d_wr  input  1  D-cache request is a write (qualified by d_req)
- d_addr  input  16  D-cache byte address; bit 0 ignored
- d_wdata  input  16  D-cache write data
- wait_for_icache  output  1  D-cache request not accepted this cycle; hold and retry
- mem_data  output  16  returned read data, shared bus
- i_data_valid  output  1  mem_data is an I-cache beat this cycle
- d_data_valid  output  1  mem_data is a D-cache beat this cycle

Behaviour:
- Arbitration is combinational and per cycle:
  - i_req=1: I-cache granted.
  - i_req=0 and d_req=1: D-cache granted.
  - wait_for_icache = d_req & i_req; no other cause.
- Fairness: none. A continuous I-cache stream starves the D-cache by design, because a fill burst must complete with back-to-back beats.
- Granted read:
  - The array word at addr[WORD_BITS:1] is sampled on the grant edge.
  - The sample enters pipeline stage 0 tagged {valid=1, owner}.
  - The pipeline is a LATENCY-deep shift register of {valid, owner, data}, advancing every cycle with no stall input.
  - The beat appears on mem_data with the owner's valid strobe exactly LATENCY cycles after the grant cycle.
  - Example: grant in cycle N means the valid strobe is high in cycle N+LATENCY.
- Throughput: one request per cycle. Back-to-back grants produce back-to-back beats in grant order. At most LATENCY beats are in flight.
- Granted D write (d_wr=1):
  - The array updates on the grant edge.
  - No response beat is produced and nothing enters the pipeline; a bubble enters stage 0.
- Read-after-write:
  - A read granted in any cycle after a write's grant cycle returns the new data.
  - A read and a write cannot be granted in the same cycle.
- Outputs:
  - i_data_valid = last_stage.valid & owner==I.
  - d_data_valid = last_stage.valid & owner==D.
  - At most one strobe is high per cycle.
  - mem_data = last_stage.data when valid, else 16'h0000.
- Address bit 0 is ignored for both requesters: address 0x1235 reads the same word as 0x1234.
- Reset (rst_n low, asynchronous):
  - All pipeline valid bits clear immediately; in-flight beats are discarded, never delivered.
  - mem_data=0, i_data_valid=0, d_data_valid=0.
  - wait_for_icache follows its combinational equation and is not held by reset.
  - Array contents are not reset.
- Reset released mid-burst: the first valid strobe can occur no earlier than LATENCY cycles after the first post-reset grant.
- Requests with req=0 are ignored regardless of address and data values.
- A D-cache request that is held while waiting is re-arbitrated every cycle, with no internal queueing. Only the cycle it is granted creates a beat or a write.

Test Plan:
- Single I read: preload word at 0x0040 = 0xBEEF; i_req=1 with i_addr=0x0040 for one cycle → i_data_valid high exactly 4 cycles later (LATENCY=4) with mem_data=0xBEEF; d_data_valid stays 0.
- Fill burst: 8 consecutive I requests at 0x0100..0x010E step 2 → 8 consecutive i_data_valid beats starting 4 cycles after the first request, data in address order, no gaps.
- Collision: i_req and d_req asserted together for 3 cycles, then i_req drops → wait_for_icache=1 for those 3 cycles; the single D read is granted in cycle 4 and its d_data_valid arrives 4 cycles later; I beats are unaffected.
- Write then read: D write 0x1234 to 0x2000, then D read of 0x2001 in the next cycle → d_data_valid beat carries 0x1234; no beat is produced for the write.
- Reset mid-pipeline: issue 3 I reads, assert rst_n=0 two cycles later → strobes drop asynchronously and no stale beat ever appears; after release, a new read returns after exactly 4 cycles.
- LATENCY=1 build: I read granted in cycle N → i_data_valid in cycle N+1; back-to-back reads produce continuous beats.
